// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the hazard controller: FSM states, forward selects, counter width.
package hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'b00,
    ST_WAIT  = 2'b01,
    ST_ERROR = 2'b10
  } state_e;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  localparam int CNT_W = 16;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Statistics counters stick at all-ones instead of wrapping back to zero.
  function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] value);
    return (value == CNT_MAX) ? value : value + CNT_W'(1);
  endfunction

endpackage

// File: rtl/hazard_ctrl_fwd.sv
// fwd_unit: picks the bypass source for one execute-stage operand.
module fwd_unit
  import hazard_ctrl_pkg::*;
(
  input  logic [4:0] rsE_i,
  input  logic [4:0] rdM_i,
  input  logic [4:0] rdW_i,
  input  logic       regWriteM_i,
  input  logic       regWriteW_i,
  output logic [1:0] fwdSel_o
);

  // The memory stage holds the younger result, so it wins over writeback; x0 is never bypassed.
  always_comb begin
    fwdSel_o = FWD_RF;
    if (regWriteM_i && (rdM_i != 5'd0) && (rdM_i == rsE_i)) begin
      fwdSel_o = FWD_MEM;
    end else if (regWriteW_i && (rdW_i != 5'd0) && (rdW_i == rsE_i)) begin
      fwdSel_o = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: operand forwarding, stall/flush priority, data-memory wait supervision and event counters.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       Rs1D,
  input  logic [4:0]       Rs2D,
  input  logic [4:0]       Rs1E,
  input  logic [4:0]       Rs2E,
  input  logic [4:0]       RdE,
  input  logic [4:0]       RdM,
  input  logic [4:0]       RdW,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic             LoadE,
  input  logic             PCSrcE,
  input  logic             MemAccessM,
  input  logic             dmem_ready,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic             mem_timeout
);

  localparam logic [7:0] TimeoutCnt = 8'(TIMEOUT);

  state_e           state_q;
  logic [7:0]       waitCnt_q;
  logic             memTimeout_q;
  logic [CNT_W-1:0] stallCnt_q;
  logic [CNT_W-1:0] stallCnt_d;
  logic [CNT_W-1:0] flushCnt_q;
  logic [CNT_W-1:0] flushCnt_d;
  logic [1:0]       fwdA;
  logic [1:0]       fwdB;
  logic             memStall;
  logic             lwStall;

  fwd_unit u_fwdA (
    .rsE_i       (Rs1E),
    .rdM_i       (RdM),
    .rdW_i       (RdW),
    .regWriteM_i (RegWriteM),
    .regWriteW_i (RegWriteW),
    .fwdSel_o    (fwdA)
  );

  fwd_unit u_fwdB (
    .rsE_i       (Rs2E),
    .rdM_i       (RdM),
    .rdW_i       (RdW),
    .regWriteM_i (RegWriteM),
    .regWriteW_i (RegWriteW),
    .fwdSel_o    (fwdB)
  );

  // Forward selects fall back to the register file while reset is held.
  always_comb begin
    ForwardAE = FWD_RF;
    ForwardBE = FWD_RF;
    if (rst_n) begin
      ForwardAE = fwdA;
      ForwardBE = fwdB;
    end
  end

  // Raw hazard conditions; a stuck memory (ERROR) keeps the whole pipe frozen.
  always_comb begin
    lwStall  = LoadE && (RdE != 5'd0) && ((RdE == Rs1D) || (RdE == Rs2D));
    memStall = (MemAccessM && !dmem_ready) || (state_q == ST_ERROR);
  end

  // Priority resolve: memory wait freezes everything, a taken branch squashes, load-use bubbles.
  always_comb begin
    StallF = 1'b0;
    StallD = 1'b0;
    StallE = 1'b0;
    StallM = 1'b0;
    FlushD = 1'b0;
    FlushE = 1'b0;
    if (rst_n) begin
      if (memStall) begin
        StallF = 1'b1;
        StallD = 1'b1;
        StallE = 1'b1;
        StallM = 1'b1;
      end else if (PCSrcE) begin
        FlushD = 1'b1;
        FlushE = 1'b1;
      end else if (lwStall) begin
        StallF = 1'b1;
        StallD = 1'b1;
        FlushE = 1'b1;
      end
    end
  end

  // Memory wait supervisor: counts WAIT cycles, readiness on the last allowed cycle still returns to RUN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_RUN;
      waitCnt_q    <= 8'd0;
      memTimeout_q <= 1'b0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (MemAccessM && !dmem_ready) begin
            state_q   <= ST_WAIT;
            waitCnt_q <= 8'd1;
          end
        end
        ST_WAIT: begin
          if (dmem_ready) begin
            state_q <= ST_RUN;
          end else begin
            waitCnt_q <= waitCnt_q + 8'd1;
            if (waitCnt_q == TimeoutCnt) begin
              state_q      <= ST_ERROR;
              memTimeout_q <= 1'b1;
            end
          end
        end
        ST_ERROR: begin
          memTimeout_q <= 1'b1;
        end
        default: begin
          state_q <= ST_RUN;
        end
      endcase
    end
  end

  // Next values for the saturating event counters.
  always_comb begin
    stallCnt_d = stallCnt_q;
    flushCnt_d = flushCnt_q;
    if (StallF) begin
      stallCnt_d = satInc(stallCnt_q);
    end
    if (FlushD || FlushE) begin
      flushCnt_d = satInc(flushCnt_q);
    end
  end

  // Event counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stallCnt_q <= '0;
      flushCnt_q <= '0;
    end else begin
      stallCnt_q <= stallCnt_d;
      flushCnt_q <= flushCnt_d;
    end
  end

  assign stall_cnt   = stallCnt_q;
  assign flush_cnt   = flushCnt_q;
  assign mem_timeout = memTimeout_q;

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have ports: clk in 1 system clock; rst_n in 1 async active-low reset.
REQ-002 SHALL have inputs Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW, each 5 bits: register indices per stage.
REQ-003 SHALL have inputs RegWriteM, RegWriteW, LoadE, PCSrcE, MemAccessM, dmem_ready, each 1 bit; LoadE flags a load in execute, PCSrcE flags a taken branch/jump, MemAccessM flags a load/store in memory.
REQ-004 SHALL have outputs ForwardAE and ForwardBE, 2 bits each: 00 regfile, 01 writeback result, 10 memory-stage ALU result.
REQ-005 SHALL have 1-bit outputs StallF, StallD, StallE, StallM and FlushD, FlushE; these drive pipeline-register en (hold when 1) and clr.
REQ-006 SHALL have outputs stall_cnt (16 bits), flush_cnt (16 bits) and mem_timeout (1 bit, sticky error).
REQ-007 SHALL have parameter TIMEOUT, default 255: the maximum number of wait cycles before an error.

Function
REQ-008 ForwardAE SHALL be 10 if RegWriteM, RdM!=0 and RdM==Rs1E; else 01 if RegWriteW, RdW!=0 and RdW==Rs1E; else 00. ForwardBE SHALL follow the same rule on Rs2E. Both are combinational, and M has priority over W.
REQ-009 lwStall SHALL equal LoadE and RdE!=0 and (RdE==Rs1D or RdE==Rs2D).
REQ-010 memStall SHALL equal MemAccessM and not dmem_ready, or state==ERROR.
REQ-011 Outputs SHALL be combinational from inputs and state, with this priority: memStall > PCSrcE > lwStall.
REQ-012 When memStall is active, StallF, StallD, StallE and StallM SHALL be 1, and FlushD and FlushE SHALL be 0.
REQ-013 When PCSrcE is active and memStall is not, FlushD and FlushE SHALL be 1 and all stalls SHALL be 0; lwStall is ignored.
REQ-014 When lwStall is active alone, StallF and StallD SHALL be 1, FlushE SHALL be 1, and StallE, StallM and FlushD SHALL be 0.
REQ-015 When no condition is active, all stall and flush outputs SHALL be 0.
REQ-016 The FSM SHALL have states RUN, WAIT and ERROR.
REQ-017 RUN SHALL go to WAIT when MemAccessM is 1 and dmem_ready is 0, clearing wait_cnt to 1.
REQ-018 WAIT SHALL go to RUN when dmem_ready is 1. Otherwise it SHALL increment wait_cnt, and go to ERROR when wait_cnt==TIMEOUT.
REQ-019 ERROR SHALL set mem_timeout to 1 and hold all stalls; it SHALL be exited only by reset.
REQ-020 wait_cnt SHALL be 8 bits.
REQ-021 stall_cnt SHALL increment once per cycle in which StallF is 1, and SHALL saturate at 0xFFFF.
REQ-022 flush_cnt SHALL increment once per cycle in which FlushD or FlushE is 1, and SHALL saturate at 0xFFFF.
REQ-023 If dmem_ready rises in the same cycle that WAIT reaches wait_cnt==TIMEOUT, the FSM SHALL go to RUN, not ERROR.
REQ-024 A load-use hazard pending during a memStall SHALL be re-evaluated after the stall ends; it SHALL NOT be lost or doubled.

Reset
REQ-025 On rst_n low, asynchronously: state=RUN, wait_cnt=0, stall_cnt=0, flush_cnt=0, mem_timeout=0.
REQ-026 While rst_n is low, all stall and flush outputs SHALL be 0 and the forward selects SHALL be 00.
REQ-027 Reset asserted mid-WAIT or in ERROR SHALL return the block to RUN with the counters cleared.
REQ-028 Reset release SHALL be synchronous to clk via a two-flop deassertion synchroniser outside this block.

Structure
REQ-029 A shared package SHALL hold: FSM state encodings, forward-select constants FWD_RF=00, FWD_WB=01, FWD_MEM=10, and the counter width (16).
REQ-030 Forwarding logic SHALL be one sub-module, fwd_unit, instantiated twice (A and B operands).
REQ-031 The FSM, counters and stall/flush priority logic SHALL reside in hazard_ctrl.

Verification
REQ-032 Forwarding: Rs1E=5, RdM=5, RegWriteM=1, RdW=5, RegWriteW=1 -> ForwardAE=10; then RdM=0 -> ForwardAE=01.
REQ-033 Load-use: LoadE=1, RdE=7, Rs2D=7 -> StallF=StallD=FlushE=1 for one cycle; stall_cnt increments by 1.
REQ-034 Branch with concurrent load-use: PCSrcE=1, LoadE=1, RdE=3, Rs1D=3 -> FlushD=FlushE=1 and StallF=0.
REQ-035 Memory wait: MemAccessM=1, dmem_ready=0 for 4 cycles, then 1 -> all four stalls held 4 cycles; state RUN->WAIT->RUN; stall_cnt=4.
REQ-036 Timeout: TIMEOUT=4, dmem_ready held at 0 -> ERROR after the 4th WAIT cycle with mem_timeout=1; after rst_n pulse, state=RUN and mem_timeout=0.
REQ-037 Saturation and reset: preload stall_cnt to 0xFFFE, stall for 3 cycles -> stall_cnt=0xFFFF; assert rst_n low mid-WAIT -> outputs are 0 immediately.
